ffi_bin_inv: RTL and testbench

- Parametrised sequential modular inverter: computes inv = a^-1 mod P for any odd prime P, with width W set at elaboration. P and W are parameters.
- Next-generation replacement for the fixed 255-bit ffi inverter. Default configuration is Curve25519 (P = 2^255-19).
- Uses binary extended Euclid, one elementary step per clock. Adds input reduction, zero-input error flagging, a busy/ignore-start handshake and a latency counter.
- Sits beside the field multiplier in the scalar-multiplication datapath and performs the final projective-to-affine conversion.

---
 rtl/ffi_bin_inv.sv | 168 ++++++++++++++++
 tb/tb_ffi_bin_inv.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ffi_bin_inv.sv
// ffi_bin_inv: sequential modular inverter, inv = a^-1 mod P, using binary
// extended Euclid with one elementary step per clock.
//
// Parameters:
//   W  - operand width in bits
//   P  - odd prime modulus, 2^(W-1) < P < 2^W
//   CW - latency counter width
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous active-low reset
//   start - request; honoured in IDLE or DONE only
//   a     - operand, captured on the edge that accepts start
//   inv   - result, stable from valid until next accepted start
//   valid - one-cycle pulse qualifying inv/err/lat
//   busy  - high in LOAD and RUN
//   err   - a mod P == 0 (inv forced to 0)
//   lat   - RUN cycles used by the last operation
module ffi_bin_inv #(
  parameter int unsigned  W  = 255,
  parameter logic [W-1:0] P  = W'((256'd1 << 255) - 256'd19),
  parameter int unsigned  CW = $clog2(4*W+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  a,
  output logic [W-1:0]  inv,
  output logic          valid,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] lat
);

  // Oddness and the top-bit window are checkable at elaboration; primality is not.
  if (W < 2 || P[0] != 1'b1 || P[W-1] != 1'b1) begin : g_bad_modulus
    $error("ffi_bin_inv: P must be odd with 2^(W-1) < P < 2^W");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t         r_state;
  state_t         w_next;

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_u;
  logic [W-1:0]   r_v;
  logic [W-1:0]   r_x1;
  logic [W-1:0]   r_x2;
  logic [W-1:0]   r_inv;
  logic           r_err;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_lat;

  logic [W-1:0]   w_ar;
  logic           w_ar_zero;
  logic           w_u_one;
  logic           w_v_one;

  // x/2 mod P: odd x is made even by adding P (W+1 bits keeps the carry).
  function automatic logic [W-1:0] f_half(input logic [W-1:0] x);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
    return s[W:1];
  endfunction

  // (p - q) mod P for p, q in [0, P): a borrow is corrected by adding P back.
  function automatic logic [W-1:0] f_msub(input logic [W-1:0] p, input logic [W-1:0] q);
    logic [W:0] d;
    d = {1'b0, p} - {1'b0, q};
    if (d[W]) d = d + {1'b0, P};
    return d[W-1:0];
  endfunction

  // a < 2^W < 2P, so one conditional subtraction fully reduces it.
  assign w_ar      = (r_a >= P) ? (r_a - P) : r_a;
  assign w_ar_zero = (w_ar == '0);
  assign w_u_one   = (r_u == W'(1));
  assign w_v_one   = (r_v == W'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD;
      S_LOAD:  w_next = w_ar_zero ? S_DONE : S_RUN;
      S_RUN:   if (w_u_one || w_v_one) w_next = S_DONE;
      S_DONE:  w_next = start ? S_LOAD : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    valid = (r_state == S_DONE);
    busy  = (r_state == S_LOAD) || (r_state == S_RUN);
  end

  assign inv = r_inv;
  assign err = r_err;
  assign lat = r_lat;

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a   <= '0;
      r_u   <= '0;
      r_v   <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_inv <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_lat <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a   <= a;
            r_err <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_ar_zero) begin
            r_err <= 1'b1;
            r_inv <= '0;
            r_lat <= '0;
          end else begin
            r_u   <= w_ar;
            r_v   <= P;
            r_x1  <= W'(1);
            r_x2  <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_u_one) begin
            r_inv <= r_x1;
            r_lat <= r_cnt + CW'(1);
          end else if (w_v_one) begin
            r_inv <= r_x2;
            r_lat <= r_cnt + CW'(1);
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_x1 <= f_half(r_x1);
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_x2 <= f_half(r_x2);
          end else if (r_u >= r_v) begin
            r_u  <= r_u - r_v;
            r_x1 <= f_msub(r_x1, r_x2);
          end else begin
            r_v  <= r_v - r_u;
            r_x2 <= f_msub(r_x2, r_x1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ffi_bin_inv.sv
module tb_ffi_bin_inv;

  localparam int unsigned   CW8  = $clog2(4*8+1);
  localparam int unsigned   CWD  = $clog2(4*255+1);
  localparam logic [511:0]  PD   = (512'd1 << 255) - 512'd19;
  localparam logic [254:0]  PD255 = PD[254:0];

  logic            clk = 1'b0;
  logic            rst = 1'b0;

  logic            start8 = 1'b0;
  logic [7:0]      a8 = '0;
  logic [7:0]      inv8;
  logic            valid8, busy8, err8;
  logic [CW8-1:0]  lat8;

  logic            startd = 1'b0;
  logic [254:0]    ad = '0;
  logic [254:0]    invd;
  logic            validd, busyd, errd;
  logic [CWD-1:0]  latd;

  ffi_bin_inv #(.W(8), .P(8'd251)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .inv(inv8),
    .valid(valid8), .busy(busy8), .err(err8), .lat(lat8)
  );

  ffi_bin_inv u_dutd (
    .clk(clk), .rst(rst), .start(startd), .a(ad), .inv(invd),
    .valid(validd), .busy(busyd), .err(errd), .lat(latd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [254:0] a;
    logic [254:0] inv;
    bit           err;
    int           lat;    // -1 when not predicted exactly
    int           start;  // index of accepting edge
  } exp_t;

  exp_t q8[$];
  exp_t qd[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input bit ok, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: inverse by exhaustive search over the field.
  function automatic int ref_inv8(input int av);
    int ar;
    ar = av % 251;
    if (ar == 0) return 0;
    for (int x = 1; x < 251; x++)
      if ((ar * x) % 251 == 1) return x;
    return -1;
  endfunction

  // Monitors: pop and compare on every valid pulse.
  always @(negedge clk) begin : mon8
    exp_t e;
    int   edges;
    if (valid8) begin
      if (q8.size() == 0) chk("unexpected_valid8", 1'b0, 1, 0);
      else begin
        e = q8.pop_front();
        chk("inv8", inv8 == e.inv[7:0], inv8, e.inv);
        chk("err8", err8 == e.err, err8, e.err);
        if (e.lat >= 0) chk("lat8", lat8 == e.lat, lat8, e.lat);
        chk("lat8_bound", lat8 <= 33, lat8, 33);
        edges = cyc - e.start + 1;
        chk("edges8", edges == (e.err ? 2 : int'(lat8) + 2), edges, e.err ? 2 : int'(lat8) + 2);
      end
    end
  end

  always @(negedge clk) begin : mond
    exp_t          e;
    int            edges;
    logic [511:0]  prod;
    if (validd) begin
      if (qd.size() == 0) chk("unexpected_validd", 1'b0, 1, 0);
      else begin
        e = qd.pop_front();
        chk("errd", errd == e.err, errd, e.err);
        if (e.err) begin
          chk("invd_zero", invd == '0, invd, 0);
          chk("latd_zero", latd == '0, latd, 0);
        end else begin
          prod = {257'b0, e.a} * {257'b0, invd};
          prod = prod % PD;
          chk("invd_product", prod == 512'd1, prod[255:0], 1);
          chk("invd_range", {257'b0, invd} < PD, invd, PD255);
          if (e.lat >= 0) chk("latd", latd == e.lat, latd, e.lat);
          chk("latd_bound", latd <= 1021, latd, 1021);
        end
        edges = cyc - e.start + 1;
        chk("edgesd", edges == (e.err ? 2 : int'(latd) + 2), edges, e.err ? 2 : int'(latd) + 2);
      end
    end
  end

  task automatic issue8(input int av, input bit hold);
    exp_t e;
    int   n;
    int   ar;
    n = 0;
    @(negedge clk);
    while (busy8 && n < 100) begin @(negedge clk); n++; end
    if (busy8) chk("busy8_timeout", 1'b0, 1, 0);
    ar    = av % 251;
    a8    = av[7:0];
    start8 = 1'b1;
    e.a   = 255'(av);
    e.inv = 255'(ref_inv8(av));
    e.err = (ar == 0);
    e.lat = (ar == 0) ? 0 : ((ar == 1) ? 1 : -1);
    e.start = cyc + 1;
    q8.push_back(e);
    if (!hold) begin @(posedge clk); #1 start8 = 1'b0; end
  endtask

  task automatic wait8();
    int n;
    n = 0;
    while (q8.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("timeout8", q8.size() == 0, q8.size(), 0);
    q8.delete();
  endtask

  task automatic issued(input logic [254:0] av);
    exp_t         e;
    int           n;
    logic [255:0] ar;
    n = 0;
    @(negedge clk);
    while (busyd && n < 2000) begin @(negedge clk); n++; end
    if (busyd) chk("busyd_timeout", 1'b0, 1, 0);
    ar     = {1'b0, av} % PD[255:0];
    ad     = av;
    startd = 1'b1;
    e.a    = av;
    e.inv  = '0;
    e.err  = (ar == '0);
    e.lat  = (ar == '0) ? 0 : ((ar == 256'd1) ? 1 : -1);
    e.start = cyc + 1;
    qd.push_back(e);
    @(posedge clk); #1 startd = 1'b0;
  endtask

  task automatic waitd();
    int n;
    n = 0;
    while (qd.size() != 0 && n < 1200) begin @(negedge clk); n++; end
    chk("timeoutd", qd.size() == 0, qd.size(), 0);
    qd.delete();
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin : stim
    logic [254:0] r;
    int           n;
    int           seen;

    // Reset state
    #1;
    chk("rst_inv8", inv8 == '0, inv8, 0);
    chk("rst_valid8", valid8 == 1'b0, valid8, 0);
    chk("rst_busy8", busy8 == 1'b0, busy8, 0);
    chk("rst_err8", err8 == 1'b0, err8, 0);
    chk("rst_lat8", lat8 == '0, lat8, 0);
    chk("rst_busyd", busyd == 1'b0, busyd, 0);
    chk("rst_invd", invd == '0, invd, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed boundary cases
    issue8(2, 0);   wait8();
    issue8(1, 0);   wait8();
    issue8(250, 0); wait8();
    issue8(251, 0); wait8();
    issue8(252, 0); wait8();
    issue8(0, 0);   wait8();
    issue8(255, 0); wait8();

    // start while busy must be ignored, a not re-captured
    issue8(2, 0);
    @(negedge clk);
    chk("busy8_during_run", busy8 == 1'b1, busy8, 1);
    a8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    wait8();
    issue8(3, 0); wait8();

    // start held: back-to-back operations, one per DONE
    issue8(7, 1);
    seen = 0; n = 0;
    while (seen < 2 && n < 200) begin
      @(negedge clk); n++;
      if (valid8) begin
        seen++;
        if (seen == 1) begin
          q8.push_back('{a: 255'd7, inv: 255'(ref_inv8(7)), err: 1'b0, lat: -1, start: cyc + 1});
        end else start8 = 1'b0;
      end
    end
    start8 = 1'b0;
    chk("b2b_count", seen == 2, seen, 2);
    wait8();

    // Default configuration
    issued(255'd18271); waitd();
    issued(PD255);      waitd();
    issued(PD255 + 255'd1); waitd();
    issued('0);         waitd();
    for (int k = 0; k < 3; k++) begin
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[222:0], 32'($urandom)};
      issued(r); waitd();
    end

    // Random sweep
    for (int k = 0; k < 30; k++) issue8(int'($urandom_range(0, 255)), 0);
    wait8();

    // Asynchronous reset mid-RUN aborts the operation
    issue8(2, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("busy8_pre_reset", busy8 == 1'b1, busy8, 1);
    rst = 1'b0;
    #1;
    chk("arst_busy8", busy8 == 1'b0, busy8, 0);
    chk("arst_valid8", valid8 == 1'b0, valid8, 0);
    chk("arst_inv8", inv8 == '0, inv8, 0);
    chk("arst_err8", err8 == 1'b0, err8, 0);
    chk("arst_invd", invd == '0, invd, 0);
    q8.delete();
    @(negedge clk);
    rst = 1'b1;
    issue8(5, 0); wait8();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
